// File: rtl/dl_and_arb_if.sv
// rtl/dl_and_arb_if.sv - request/response bundle for the round-robin AND arbiter
//
// Purpose: groups the per-requester request lanes and the single response
// channel of dl_and_arb so they travel as one port.
// Signals:
//   req_val   [NUM_REQ]           per-requester request valid
//   req_rdy   [NUM_REQ]           per-requester accept (one-hot or zero)
//   req_a     [NUM_REQ*NUM_BITS]  operand A, requester i at [i*NUM_BITS +: NUM_BITS]
//   req_b     [NUM_REQ*NUM_BITS]  operand B, same packing
//   resp_val  [1]                 result valid
//   resp_rdy  [1]                 consumer accept
//   resp_data [NUM_BITS]          A AND B of the granted request
//   resp_id   [IDW]               index of the requester that produced resp_data
// Modports: master = requesters + consumer side, slave = arbiter side.
interface dl_and_arb_if #(
  parameter int NUM_BITS = 32,
  parameter int NUM_REQ  = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]          req_val;
  logic [NUM_REQ-1:0]          req_rdy;
  logic [NUM_REQ*NUM_BITS-1:0] req_a;
  logic [NUM_REQ*NUM_BITS-1:0] req_b;
  logic                        resp_val;
  logic                        resp_rdy;
  logic [NUM_BITS-1:0]         resp_data;
  logic [IDW-1:0]              resp_id;

  modport master (
    output req_val, req_a, req_b, resp_rdy,
    input  req_rdy, resp_val, resp_data, resp_id
  );

  modport slave (
    input  req_val, req_a, req_b, resp_rdy,
    output req_rdy, resp_val, resp_data, resp_id
  );
endinterface

// File: rtl/dl_and_arb.sv
// rtl/dl_and_arb.sv - round-robin arbiter feeding a shared registered AND datapath
//
// Purpose: NUM_REQ requesters compete for one bitwise-AND unit. A round-robin
// pointer picks the winner whenever the single result register is free; the
// winner's A & B is registered together with its index.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset; discards any held result
//   bus  - dl_and_arb_if.slave: request lanes in, response channel out
module dl_and_arb #(
  parameter int NUM_BITS = 32,
  parameter int NUM_REQ  = 4
) (
  input  logic         clk,
  input  logic         rst,
  dl_and_arb_if.slave  bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [NUM_BITS-1:0] data_q, data_d;

  logic                slot_free;
  logic                any_win;
  logic                xfer;
  int                  win_idx;
  int                  cand;
  logic [NUM_REQ-1:0]  rdy;
  logic [NUM_BITS-1:0] a_sel, b_sel;

  // The slot can take a new result when empty, or when the held result is
  // being drained this very cycle.
  assign slot_free = (state_q == EMPTY) || bus.resp_rdy;

  // Round-robin search: walk candidates ptr, ptr+1, ... with wrap, and take
  // the first one whose req_val is set. Operands are deliberately not looked
  // at here so req_rdy never depends on data.
  always_comb begin
    any_win = 1'b0;
    win_idx = 0;
    cand    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any_win && (cand == i) && bus.req_val[i]) begin
          any_win = 1'b1;
          win_idx = i;
        end
      end
    end
  end

  // Grant is suppressed while reset is high so nothing is accepted that the
  // reset edge would then throw away.
  always_comb begin
    rdy = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rdy[i] = any_win && slot_free && !rst && (win_idx == i);
    end
  end

  assign xfer = |rdy;

  // Operand mux for the winner.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == i) begin
        a_sel = bus.req_a[i*NUM_BITS +: NUM_BITS];
        b_sel = bus.req_b[i*NUM_BITS +: NUM_BITS];
      end
    end
  end

  // Next-state and result-register update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    data_d  = data_q;
    if (xfer) begin
      // Covers both refill from EMPTY and drain+refill in the same cycle.
      state_d = FULL;
      data_d  = a_sel & b_sel;
      id_d    = IDW'(win_idx);
      ptr_d   = (win_idx == NUM_REQ - 1) ? '0 : IDW'(win_idx + 1);
    end else if ((state_q == FULL) && bus.resp_rdy) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      data_q  <= data_d;
    end
  end

  assign bus.req_rdy   = rdy;
  assign bus.resp_val  = (state_q == FULL);
  assign bus.resp_data = data_q;
  assign bus.resp_id   = id_q;
endmodule

// File: tb/tb_dl_and_arb.sv
// tb/tb_dl_and_arb.sv - randomized self-checking bench for dl_and_arb
module tb_dl_and_arb;
  localparam int NB = 8;
  localparam int NR = 4;

  logic          clk;
  logic          rst;
  logic [NR-1:0] req_val;
  logic          resp_rdy;
  logic [NB-1:0] a [NR];
  logic [NB-1:0] b [NR];

  int n_vec;
  int n_err;

  // Reference model: pointer, queue of results awaiting the consumer
  // (at most one), and per-requester count of transfers lost while waiting.
  int m_ptr;
  int q_id[$];
  int q_dat[$];
  int waitc[NR];
  int last_g;

  dl_and_arb_if #(.NUM_BITS(NB), .NUM_REQ(NR)) bus ();

  dl_and_arb #(.NUM_BITS(NB), .NUM_REQ(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.req_val  = req_val;
  assign bus.resp_rdy = resp_rdy;
  assign bus.req_a    = {a[3], a[2], a[1], a[0]};
  assign bus.req_b    = {b[3], b[2], b[1], b[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check the DUT against the model mid-cycle, then advance the model.
  task automatic cycle();
    int g;
    logic free;
    logic [NR-1:0] exp_rdy;
    @(negedge clk);
    free = (q_id.size() == 0) || resp_rdy;
    g = -1;
    if (!rst && free) begin
      for (int k = 0; k < NR; k++) begin
        int idx;
        idx = (m_ptr + k) % NR;
        if (g < 0 && req_val[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_rdy", 64'(bus.req_rdy), 64'(exp_rdy));
    chk("resp_val", 64'(bus.resp_val), (q_id.size() != 0) ? 64'd1 : 64'd0);
    if (q_id.size() != 0) begin
      chk("resp_data", 64'(bus.resp_data), 64'(q_dat[0]));
      chk("resp_id", 64'(bus.resp_id), 64'(q_id[0]));
    end
    for (int i = 0; i < NR; i++) begin
      if (rst || !req_val[i] || g == i) begin
        waitc[i] = 0;
      end else if (g >= 0) begin
        waitc[i]++;
        chk("starve", (waitc[i] > NR - 1) ? 64'd1 : 64'd0, 64'd0);
      end
    end
    if (rst) begin
      q_id.delete();
      q_dat.delete();
      m_ptr = 0;
    end else begin
      if (q_id.size() != 0 && resp_rdy) begin
        void'(q_id.pop_front());
        void'(q_dat.pop_front());
      end
      if (g >= 0) begin
        q_id.push_back(g);
        q_dat.push_back(int'(a[g] & b[g]));
        m_ptr = (g + 1) % NR;
      end
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    req_val  = 4'hF;
    resp_rdy = 1'b1;
    cycle();
    rst     = 1'b0;
    req_val = '0;
    chk("rst_val", 64'(bus.resp_val), 64'd0);
    chk("rst_data", 64'(bus.resp_data), 64'd0);
    chk("rst_id", 64'(bus.resp_id), 64'd0);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    m_ptr    = 0;
    last_g   = -1;
    rst      = 1'b1;
    req_val  = '0;
    resp_rdy = 1'b0;
    for (int i = 0; i < NR; i++) begin
      a[i] = '0;
      b[i] = '0;
      waitc[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single request.
    req_val  = 4'b0001;
    a[0]     = 8'hF0;
    b[0]     = 8'h3C;
    resp_rdy = 1'b1;
    cycle();
    chk("single_val", 64'(bus.resp_val), 64'd1);
    chk("single_data", 64'(bus.resp_data), 64'h30);
    chk("single_id", 64'(bus.resp_id), 64'd0);
    req_val = '0;
    cycle();

    // All requesting from reset: grants 0,1,2,3,0 back to back.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      a[i] = NB'($urandom);
      b[i] = NB'($urandom);
    end
    req_val  = 4'hF;
    resp_rdy = 1'b1;
    for (int n = 0; n < 5; n++) begin
      cycle();
      chk("rr_id", 64'(bus.resp_id), 64'(n % NR));
      chk("rr_data", 64'(bus.resp_data), 64'(a[n % NR] & b[n % NR]));
    end

    // Backpressure: 0xAA held while resp_rdy=0, then grant follows ptr.
    do_reset();
    req_val  = 4'b0001;
    a[0]     = 8'hAA;
    b[0]     = 8'hFF;
    resp_rdy = 1'b1;
    cycle();
    resp_rdy = 1'b0;
    req_val  = 4'hF;
    repeat (5) begin
      cycle();
      chk("bp_data", 64'(bus.resp_data), 64'hAA);
      chk("bp_id", 64'(bus.resp_id), 64'd0);
    end
    resp_rdy = 1'b1;
    cycle();
    chk("bp_next_id", 64'(bus.resp_id), 64'd1);

    // Wrap and skip: ptr=3, req_val=0101 -> 0 then 2.
    do_reset();
    req_val  = 4'b0100;
    resp_rdy = 1'b1;
    cycle();
    req_val = 4'b0101;
    cycle();
    chk("wrap_id0", 64'(bus.resp_id), 64'd0);
    cycle();
    chk("wrap_id2", 64'(bus.resp_id), 64'd2);

    // Reset while FULL and stalled.
    req_val  = 4'b0001;
    resp_rdy = 1'b0;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_val", 64'(bus.resp_val), 64'd0);
    chk("midrst_data", 64'(bus.resp_data), 64'd0);
    chk("midrst_id", 64'(bus.resp_id), 64'd0);
    req_val  = 4'b1000;
    resp_rdy = 1'b1;
    cycle();
    chk("midrst_g3", 64'(bus.resp_id), 64'd3);
    req_val = 4'hF;
    cycle();
    chk("midrst_g0", 64'(bus.resp_id), 64'd0);

    // Random stress.
    req_val = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (req_val[i] && last_g != i) begin
          req_val[i] = ($urandom_range(0, 9) != 0);
        end else if ($urandom_range(0, 1) == 1) begin
          req_val[i] = 1'b1;
          a[i] = NB'($urandom);
          b[i] = NB'($urandom);
        end else begin
          req_val[i] = 1'b0;
        end
      end
      resp_rdy = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
